key_bounce_gen: RTL
===================

Name: key_bounce_gen

Overview:
- Synthesizable bouncing-key generator; the driving end of the key debounce interface.
- On a start pulse it emits one complete press: idle-high, random pre-bounce, stable low, random post-bounce, release high.
- Feeds a key debouncer in on-board self-test and loopback benches, replacing a physical button.
- Bounce patterns come from a 16-bit LFSR, so sequences are deterministic and repeatable.

Parameters:
BOUNCE_CYCLES, 100, length in clocks of each bounce phase (pre and post); must be >= 1.
HOLD_CYCLES, 300, default stable-low length in clocks when hold_len = 0; must be >= 1.
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1.

Ports:
sclk       input   1   system clock; all logic is on its rising edge.
s_rst      input   1   asynchronous, active-high reset.
start      input   1   one-clock request to generate one press; sampled only in IDLE.
abort      input   1   ends the current press immediately.
hold_len   input   16  stable-low length in clocks, latched at start; 0 selects HOLD_CYCLES.
key        output  1   generated key level; 1 = released, 0 = pressed.
busy       output  1   high in every non-IDLE state.
done       output  1   one-clock pulse when a press completes normally.
press_cnt  output  8   count of completed presses; wraps 255 -> 0.

Behaviour:
- Reset values (async, while s_rst = 1): state = IDLE, key = 1, busy = 0, done = 0, press_cnt = 0, lfsr = LFSR_SEED (or 16'hACE1 if the seed is 0), phase counter = 0.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, taps 16, 14, 13, 11.
  - Shifts every clock in every state: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - It can never reach 0.
- States: IDLE, PRE, HOLD, POST. `key` is updated on the same edge as the state, so it reflects the state being entered.
- IDLE:
  - key = 1.
  - When start = 1, on the next edge: go to PRE, latch hold_eff (hold_len, or HOLD_CYCLES if hold_len = 0), load the phase counter, and set key = next lfsr[0].
- PRE:
  - Lasts exactly BOUNCE_CYCLES clocks.
  - key = lfsr[0] of the new LFSR value each clock.
  - Then go to HOLD.
- HOLD:
  - Lasts exactly hold_eff clocks with key = 0.
  - Then go to POST.
- POST:
  - Lasts exactly BOUNCE_CYCLES clocks with key = lfsr[0].
  - Then go to IDLE with key = 1.
  - done = 1 for the first IDLE cycle only.
  - press_cnt increments on the same edge.
- Total press time, from the first PRE cycle to the first IDLE cycle: 2*BOUNCE_CYCLES + hold_eff clocks.
- Latency: start sampled high at edge N gives the first bounce value on key after edge N.
- Phase counter:
  - 16-bit, counts down to 1.
  - Its width must cover max(BOUNCE_CYCLES, 65535).
- Boundary rules:
  - start while busy: ignored; no queuing.
  - start on the same edge that returns to IDLE: ignored (the state is POST at that edge).
  - abort in any non-IDLE state: the next edge goes to IDLE, key = 1, done = 0, press_cnt unchanged.
  - abort and start together in IDLE: abort wins; stay IDLE.
  - hold_len changes mid-press: no effect (the value was latched at start).
  - Reset mid-press: immediate return to reset values; no done pulse.
  - press_cnt at 255 on completion: becomes 0.

Test Plan:
1. Reset, then start pulse with hold_len = 0 and defaults -> busy high for exactly 500 clocks; key = 0 continuously for the middle 300; done pulses once on the 501st cycle; press_cnt = 1; key = 1 thereafter.
2. hold_len = 16'd5, BOUNCE_CYCLES = 3 -> key low for exactly 5 clocks between two 3-clock bounce windows; busy width = 11.
3. Repeat scenario 1 from reset twice -> the bounce-window bit sequences match bit-for-bit, and match a reference LFSR model seeded with 16'hACE1.
4. start pulses during HOLD and on the final POST clock -> ignored; only one done; press_cnt = 1.
5. abort on the 50th HOLD clock -> key = 1 and busy = 0 after the next edge; no done; press_cnt unchanged. Assert s_rst mid-PRE -> key = 1 and press_cnt = 0 immediately (asynchronously).
6. 256 back-to-back presses with tiny parameters -> press_cnt wraps to 0; a connected key debouncer (delay 110) reports exactly 256 presses.

Source files
------------

// File: rtl/key_bounce_gen.sv
// Bouncing-key generator: one start pulse yields idle-high, LFSR pre-bounce, stable low, LFSR post-bounce, release.
// Latency: start sampled at edge N puts the first bounce bit on key after edge N; all outputs registered.
// Backpressure: none; start is ignored while busy and abort returns to IDLE on the next edge.
module key_bounce_gen #(
    parameter int unsigned BOUNCE_CYCLES = 100,
    parameter int unsigned HOLD_CYCLES   = 300,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] hold_len,
    output logic        key,
    output logic        busy,
    output logic        done,
    output logic [7:0]  press_cnt
);
    localparam int unsigned CNT_W = (BOUNCE_CYCLES > 65535) ? $clog2(BOUNCE_CYCLES + 1) : 16;
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0] HOLD_DFLT = 16'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        HOLD = 2'd2,
        POST = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]      hold_q;
    logic [15:0]      hold_d;
    logic [15:0]      lfsr_q;
    logic [15:0]      lfsr_d;
    logic             key_d;
    logic             busy_d;
    logic             done_d;
    logic [7:0]       press_d;

    // Fibonacci taps 16,14,13,11; a non-zero seed can never reach the all-zero lockup
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            lfsr_q    <= SEED_EFF;
            key       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            lfsr_q    <= lfsr_d;
            key       <= key_d;
            busy      <= busy_d;
            done      <= done_d;
            press_cnt <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        key_d   = key;
        done_d  = 1'b0;
        press_d = press_cnt;

        unique case (state_q)
            IDLE: begin
                key_d = 1'b1;
                if (start && !abort) begin
                    state_d = PRE;
                    hold_d  = (hold_len == 16'd0) ? HOLD_DFLT : hold_len;
                    cnt_d   = BOUNCE_LD;
                    key_d   = lfsr_d[0];
                end
            end
            PRE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(hold_q);
                    key_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    key_d = lfsr_d[0];
                end
            end
            HOLD: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = POST;
                    cnt_d   = BOUNCE_LD;
                    key_d   = lfsr_d[0];
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    key_d = 1'b0;
                end
            end
            POST: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    key_d   = 1'b1;
                    done_d  = 1'b1;
                    press_d = press_cnt + 8'd1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    key_d = lfsr_d[0];
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                key_d   = 1'b1;
            end
        endcase

        // abort overrides any completion on the same edge
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            key_d   = 1'b1;
            done_d  = 1'b0;
            press_d = press_cnt;
        end

        busy_d = (state_d != IDLE);
    end
endmodule
